// File: rtl/apb_mtimer_pkg.sv
// Shared definitions for the APB machine timer: register offsets,
// CTRL field positions and the 64-bit time type.
package apb_mtimer_pkg;

  typedef logic [63:0] mtime_t;

  // Word index (paddr[4:2]) of each register
  localparam logic [2:0] REG_MTIME_LO    = 3'd0;
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_CTRL        = 3'd4;

  // CTRL fields
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int CTRL_PRESC_MSB = 15;

  // Compare value out of reset: never matches, so the irq stays low
  localparam mtime_t MTIMECMP_RST = '1;

endpackage

// File: rtl/apb_mtimer.sv
// APB machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp and
// a registered level interrupt raised while mtime >= mtimecmp.
module apb_mtimer
  import apb_mtimer_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [DataWidth-1:0] pwdata_i,
  output logic [DataWidth-1:0] prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic                 timer_irq_o
);

  mtime_t     mtime_q, mtime_d;
  mtime_t     cmp_q, cmp_d;
  logic       en_q, en_d;
  logic [7:0] presc_q, presc_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic       irq_q;

  logic       access, wr;
  logic [2:0] idx;
  logic       wr_lo, wr_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
  logic       presc_hit, tick;
  logic [31:0] rdata;

  // Only bits [4:2] of the address are decoded
  logic unused_addr;
  assign unused_addr = ^{paddr_i[AddrWidth-1:5], paddr_i[1:0]};

  assign access    = psel_i & penable_i;
  assign wr        = access & pwrite_i;
  assign idx       = paddr_i[4:2];
  assign wr_lo     = wr && (idx == REG_MTIME_LO);
  assign wr_hi     = wr && (idx == REG_MTIME_HI);
  assign wr_cmp_lo = wr && (idx == REG_MTIMECMP_LO);
  assign wr_cmp_hi = wr && (idx == REG_MTIMECMP_HI);
  assign wr_ctrl   = wr && (idx == REG_CTRL);

  // Prescaler wraps on a hit; a software write to mtime swallows the tick
  // but the prescaler still restarts so the tick cadence is unchanged.
  assign presc_hit = en_q && (pcnt_q == presc_q);
  assign tick      = presc_hit && !wr_lo && !wr_hi;

  // Next-state for counter, compare and control; writes win over ticks
  always_comb begin
    mtime_d = mtime_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    if (tick)      mtime_d = mtime_q + 64'd1;
    if (wr_lo)     mtime_d = {mtime_q[63:32], pwdata_i[31:0]};
    if (wr_hi)     mtime_d = {pwdata_i[31:0], mtime_q[31:0]};
    if (wr_cmp_lo) cmp_d   = {cmp_q[63:32], pwdata_i[31:0]};
    if (wr_cmp_hi) cmp_d   = {pwdata_i[31:0], cmp_q[31:0]};
    if (en_q)      pcnt_d  = presc_hit ? 8'd0 : pcnt_q + 8'd1;
    if (wr_ctrl) begin
      en_d    = pwdata_i[CTRL_EN_BIT];
      presc_d = pwdata_i[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
      pcnt_d  = 8'd0;
    end
  end

  // State registers; irq compares the values being loaded this edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q <= '0;
      cmp_q   <= MTIMECMP_RST;
      en_q    <= 1'b1;
      presc_q <= 8'd0;
      pcnt_q  <= 8'd0;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      irq_q   <= (mtime_d >= cmp_d);
    end
  end

  // Combinational read mux; holes and non-read cycles return 0
  always_comb begin
    rdata = '0;
    if (psel_i && !pwrite_i) begin
      case (idx)
        REG_MTIME_LO:    rdata = mtime_q[31:0];
        REG_MTIME_HI:    rdata = mtime_q[63:32];
        REG_MTIMECMP_LO: rdata = cmp_q[31:0];
        REG_MTIMECMP_HI: rdata = cmp_q[63:32];
        REG_CTRL: begin
          rdata[CTRL_EN_BIT]                   = en_q;
          rdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = presc_q;
        end
        default:         rdata = '0;
      endcase
    end
  end

  assign prdata_o    = rdata;
  assign pready_o    = 1'b1;
  assign pslverr_o   = access && (idx > REG_CTRL);
  assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_apb_mtimer.sv
// Directed bench for apb_mtimer: reset state, compare/irq, wrap,
// prescaler, error decode, half writes and async reset.
module tb_apb_mtimer;

  logic        clk;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr, irq;

  int checks   = 0;
  int failures = 0;

  apb_mtimer #(.AddrWidth(32), .DataWidth(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .psel_i     (psel),
    .penable_i  (penable),
    .pwrite_i   (pwrite),
    .paddr_i    (paddr),
    .pwdata_i   (pwdata),
    .prdata_o   (prdata),
    .pready_o   (pready),
    .pslverr_o  (pslverr),
    .timer_irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Setup phase on a negedge, access phase on the next negedge, the
  // transfer completes on the following posedge; returns #1 after it.
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                           output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Same phasing as a write; data sampled mid access phase
  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(negedge clk);
    penable = 1'b1;
    #1 data = prdata; err = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
    checks++; if (prdata !== 32'h0) begin failures++; $display("FAIL rst_mtime got=%h exp=0", prdata); end
    checks++; if (pready !== 1'b1 || pslverr !== 1'b0) begin failures++; $display("FAIL rst_ready_err got=%b%b exp=10", pready, pslverr); end
    paddr = 32'h8; #1;
    checks++; if (prdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_cmp_lo got=%h exp=ffffffff", prdata); end
    paddr = 32'h10; #1;
    checks++; if (prdata !== 32'h1) begin failures++; $display("FAIL rst_ctrl got=%h exp=1", prdata); end
    paddr = 32'h0;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (prdata !== 32'h0) begin failures++; $display("FAIL rst_release got=%h exp=0", prdata); end
    // first edge after release ticks
    @(posedge clk); #1;
    checks++; if (prdata !== 32'd1) begin failures++; $display("FAIL first_tick got=%0d exp=1", prdata); end
    repeat (9) @(posedge clk);
    #1;
    checks++; if (prdata !== 32'd10) begin failures++; $display("FAIL ten_cycles got=%0d exp=10", prdata); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ten_irq got=%b exp=0", irq); end
    psel = 1'b0;
  endtask

  task automatic test_irq();
    logic [31:0] d; logic e;
    apb_write(32'h10, 32'h0, e);          // freeze
    apb_write(32'h0C, 32'h0, e);
    apb_write(32'h08, 32'd50, e);
    apb_write(32'h04, 32'h0, e);
    apb_write(32'h00, 32'd49, e);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_49 got=%b exp=0", irq); end
    apb_write(32'h00, 32'd50, e);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_50 got=%b exp=1", irq); end
    apb_read(32'h00, d, e);
    checks++; if (d !== 32'd50) begin failures++; $display("FAIL frozen_50 got=%0d exp=50", d); end
    apb_write(32'h08, 32'hFFFF_FFFF, e);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", irq); end
    // live count from 48 up to compare 50
    apb_write(32'h08, 32'd50, e);
    apb_write(32'h00, 32'd48, e);
    apb_write(32'h10, 32'h1, e);          // enable, no tick on this edge
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL live_48 got=%b exp=0", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL live_49 got=%b exp=0", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL live_50 got=%b exp=1", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL live_51 got=%b exp=1", irq); end
    apb_write(32'h10, 32'h0, e);
    apb_write(32'h08, 32'hFFFF_FFFF, e);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL live_fall got=%b exp=0", irq); end
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic e;
    apb_write(32'h04, 32'hFFFF_FFFF, e);
    apb_write(32'h00, 32'hFFFF_FFFE, e);
    apb_write(32'h10, 32'h1, e);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL pre_wrap_irq got=%b exp=1", irq); end
    @(posedge clk);                       // -> all ones
    apb_read(32'h00, d, e);               // sampled after wrap edge
    checks++; if (d !== 32'h0 || e !== 1'b0) begin failures++; $display("FAIL wrap_lo got=%h err=%b exp=0 err=0", d, e); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL wrap_irq got=%b exp=0", irq); end
    apb_read(32'h04, d, e);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL wrap_hi got=%h exp=0", d); end
  endtask

  task automatic test_presc();
    logic [31:0] d, v0, v1, v2; logic e;
    apb_write(32'h10, 32'h0000_0301, e);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL ctrl_err got=%b exp=0", e); end
    apb_read(32'h10, d, e);
    checks++; if (d !== 32'h0000_0301) begin failures++; $display("FAIL ctrl_rd got=%h exp=00000301", d); end
    // successive samples are exactly 4 edges apart
    apb_read(32'h00, v0, e);
    repeat (2) @(posedge clk);
    apb_read(32'h00, v1, e);
    repeat (2) @(posedge clk);
    apb_read(32'h00, v2, e);
    checks++; if (v1 - v0 !== 32'd1) begin failures++; $display("FAIL presc_d1 got=%0d exp=1", v1 - v0); end
    checks++; if (v2 - v1 !== 32'd1) begin failures++; $display("FAIL presc_d2 got=%0d exp=1", v2 - v1); end
    apb_write(32'h10, 32'h0, e);
    apb_read(32'h00, v0, e);
    repeat (20) @(posedge clk);
    apb_read(32'h00, v1, e);
    checks++; if (v1 !== v0) begin failures++; $display("FAIL frozen got=%h exp=%h", v1, v0); end
    apb_read(32'h10, d, e);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL ctrl_zero got=%h exp=0", d); end
  endtask

  task automatic test_slverr();
    logic [31:0] d, m0; logic e;
    apb_read(32'h00, m0, e);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL valid_err got=%b exp=0", e); end
    apb_write(32'h14, 32'hDEAD_BEEF, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL wr14_err got=%b exp=1", e); end
    apb_read(32'h14, d, e);
    checks++; if (d !== 32'h0 || e !== 1'b1) begin failures++; $display("FAIL rd14 got=%h err=%b exp=0 err=1", d, e); end
    apb_read(32'h1C, d, e);
    checks++; if (d !== 32'h0 || e !== 1'b1) begin failures++; $display("FAIL rd1c got=%h err=%b exp=0 err=1", d, e); end
    apb_write(32'h18, 32'hFFFF_FFFF, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL wr18_err got=%b exp=1", e); end
    apb_read(32'h00, d, e);
    checks++; if (d !== m0) begin failures++; $display("FAIL hole_mtime got=%h exp=%h", d, m0); end
    apb_read(32'h08, d, e);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL hole_cmp got=%h exp=ffffffff", d); end
    apb_read(32'h10, d, e);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL hole_ctrl got=%h exp=0", d); end
    // setup phase to a hole: no error yet
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h14;
    #1;
    checks++; if (pslverr !== 1'b0) begin failures++; $display("FAIL setup_err got=%b exp=0", pslverr); end
    paddr = 32'h0C; penable = 1'b1; #1;
    checks++; if (pready !== 1'b1 || pslverr !== 1'b0) begin failures++; $display("FAIL valid_ready got=%b%b exp=10", pready, pslverr); end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_half_write();
    logic [31:0] d; logic e;
    apb_write(32'h00, 32'h1111_1111, e);
    apb_write(32'h04, 32'h2222_2222, e);
    apb_read(32'h00, d, e);
    checks++; if (d !== 32'h1111_1111) begin failures++; $display("FAIL half_lo got=%h exp=11111111", d); end
    apb_read(32'h04, d, e);
    checks++; if (d !== 32'h2222_2222) begin failures++; $display("FAIL half_hi got=%h exp=22222222", d); end
    apb_write(32'h04, 32'h3333_3333, e);
    apb_read(32'h00, d, e);
    checks++; if (d !== 32'h1111_1111) begin failures++; $display("FAIL keep_lo got=%h exp=11111111", d); end
    // write while counting: value lands exactly, next edge adds one
    apb_write(32'h10, 32'h1, e);
    apb_write(32'h00, 32'd5, e);
    apb_read(32'h00, d, e);
    checks++; if (d !== 32'd6) begin failures++; $display("FAIL write_wins got=%0d exp=6", d); end
  endtask

  task automatic test_async_reset();
    logic e;
    apb_write(32'h0C, 32'h0, e);
    apb_write(32'h08, 32'h0, e);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL pre_rst_irq got=%b exp=1", irq); end
    @(posedge clk); #2;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
    rst = 1'b1;
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL arst_irq got=%b exp=0", irq); end
    checks++; if (prdata !== 32'h0) begin failures++; $display("FAIL arst_mtime got=%h exp=0", prdata); end
    paddr = 32'h8; #1;
    checks++; if (prdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL arst_cmp got=%h exp=ffffffff", prdata); end
    // write held across an edge while in reset is discarded
    paddr = 32'h0; pwdata = 32'h55; pwrite = 1'b1; penable = 1'b1;
    @(posedge clk); #1;
    pwrite = 1'b0; penable = 1'b0; #1;
    checks++; if (prdata !== 32'h0) begin failures++; $display("FAIL arst_wr got=%h exp=0", prdata); end
    @(negedge clk); rst = 1'b0; psel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    test_reset();
    test_irq();
    test_wrap();
    test_presc();
    test_slverr();
    test_half_write();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
